// File: rtl/lbus_pkg.sv
// Shared types and constants for the local-bus interconnect.
package lbus_pkg;

  // Transaction FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lbus_state_t;

  // Write enable / size codes presented on we and s_we.
  localparam logic [2:0] WE_NONE = 3'b000;
  localparam logic [2:0] WE_BYTE = 3'b001;
  localparam logic [2:0] WE_HALF = 3'b011;
  localparam logic [2:0] WE_WORD = 3'b111;

  // Width of the stall counter; covers the full TIMEOUT range.
  localparam int CNT_W = 16;

  // Default peripheral map for the 32-bit SoC.
  localparam logic [31:0] RAM_BASE   = 32'h0000_0000;
  localparam logic [31:0] RAM_MASK   = 32'hFFFF_0000;
  localparam logic [31:0] GPIO_BASE  = 32'h1000_0000;
  localparam logic [31:0] GPIO_MASK  = 32'hFFFF_F000;
  localparam logic [31:0] VGA_BASE   = 32'h2000_0000;
  localparam logic [31:0] VGA_MASK   = 32'hFFFF_0000;
  localparam logic [31:0] TIMER_BASE = 32'h3000_0000;
  localparam logic [31:0] TIMER_MASK = 32'hFFFF_FF00;

  // Pack four 32-bit entries into a BASE_LIST/MASK_LIST vector; e0 lands in the low bits.
  function automatic logic [127:0] pack4(input logic [31:0] e0,
                                         input logic [31:0] e1,
                                         input logic [31:0] e2,
                                         input logic [31:0] e3);
    return {e3, e2, e1, e0};
  endfunction

endpackage

// File: rtl/lbus_decoder.sv
// Address decoder: one-hot region hit with lowest-index priority, plus unmapped flag.
module lbus_decoder
  import lbus_pkg::*;
#(
  parameter int                     XLEN      = 32,
  parameter int                     NSLV      = 4,
  parameter logic [NSLV*XLEN-1:0]   BASE_LIST = {(NSLV*XLEN){1'b0}},
  parameter logic [NSLV*XLEN-1:0]   MASK_LIST = {NSLV{{16{1'b1}}, {(XLEN-16){1'b0}}}}
) (
  input  logic [XLEN-1:0] addr,
  output logic [NSLV-1:0] hit,
  output logic            unmapped
);

  logic found;

  // Scan regions from index 0 upward; the first match claims the access.
  always_comb begin
    hit   = {NSLV{1'b0}};
    found = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (!found && ((addr & MASK_LIST[i*XLEN +: XLEN]) == BASE_LIST[i*XLEN +: XLEN])) begin
        hit[i] = 1'b1;
        found  = 1'b1;
      end else begin
        hit[i] = 1'b0;
      end
    end
    unmapped = ~found;
  end

endmodule

// File: rtl/lbus_interconnect.sv
// Local-bus interconnect: decode, per-slave handshake with timeout, registered response.
module lbus_interconnect
  import lbus_pkg::*;
#(
  parameter int                     XLEN      = 32,
  parameter int                     NSLV      = 4,
  parameter logic [NSLV*XLEN-1:0]   BASE_LIST = {(NSLV*XLEN){1'b0}},
  parameter logic [NSLV*XLEN-1:0]   MASK_LIST = {NSLV{{16{1'b1}}, {(XLEN-16){1'b0}}}},
  parameter int                     TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic [XLEN-1:0]      addr,
  input  logic [XLEN-1:0]      qin,
  input  logic [2:0]           we,
  output logic [XLEN-1:0]      qout,
  output logic                 ready,
  output logic                 err,
  output logic [XLEN-1:0]      err_addr,
  output logic [NSLV-1:0]      s_sel,
  output logic [XLEN-1:0]      s_addr,
  output logic [XLEN-1:0]      s_qin,
  output logic [2:0]           s_we,
  input  logic [NSLV*XLEN-1:0] s_qout,
  input  logic [NSLV-1:0]      s_ready
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  lbus_state_t       state;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   addr_lat;
  logic [NSLV-1:0]   hit;
  logic              unmapped;
  logic [XLEN-1:0]   hit_base;
  logic [XLEN-1:0]   rd_data;
  logic              sel_ready;

  lbus_decoder #(
    .XLEN      (XLEN),
    .NSLV      (NSLV),
    .BASE_LIST (BASE_LIST),
    .MASK_LIST (MASK_LIST)
  ) u_dec (
    .addr     (addr),
    .hit      (hit),
    .unmapped (unmapped)
  );

  // Base of the decoded region and read data of the selected slave (one-hot AND-OR muxes).
  always_comb begin
    hit_base = {XLEN{1'b0}};
    rd_data  = {XLEN{1'b0}};
    for (int i = 0; i < NSLV; i++) begin
      hit_base = hit_base | (BASE_LIST[i*XLEN +: XLEN] & {XLEN{hit[i]}});
      rd_data  = rd_data  | (s_qout[i*XLEN +: XLEN]    & {XLEN{s_sel[i]}});
    end
  end

  // Only the selected channel's strobe counts; strays on other channels are masked.
  assign sel_ready = |(s_ready & s_sel);

  // Transaction FSM with stall counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= {CNT_W{1'b0}};
      addr_lat <= {XLEN{1'b0}};
      s_sel    <= {NSLV{1'b0}};
      s_we     <= WE_NONE;
      s_addr   <= {XLEN{1'b0}};
      s_qin    <= {XLEN{1'b0}};
      qout     <= {XLEN{1'b0}};
      ready    <= 1'b0;
      err      <= 1'b0;
      err_addr <= {XLEN{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b0;
          cnt   <= {CNT_W{1'b0}};
          if (req) begin
            addr_lat <= addr;
            s_qin    <= qin;
            if (unmapped) begin
              // No region claims the address: fault immediately.
              state    <= RESP;
              ready    <= 1'b1;
              err      <= 1'b1;
              qout     <= {XLEN{1'b0}};
              err_addr <= addr;
            end else begin
              state  <= ACCESS;
              s_sel  <= hit;
              s_addr <= addr - hit_base;
              s_we   <= we;
            end
          end
        end

        ACCESS: begin
          if (sel_ready) begin
            // Slave completion takes precedence over a coincident timeout.
            state <= RESP;
            ready <= 1'b1;
            err   <= 1'b0;
            qout  <= (s_we == WE_NONE) ? rd_data : {XLEN{1'b0}};
            s_sel <= {NSLV{1'b0}};
            s_we  <= WE_NONE;
          end else if (cnt == TMO) begin
            state    <= RESP;
            ready    <= 1'b1;
            err      <= 1'b1;
            qout     <= {XLEN{1'b0}};
            err_addr <= addr_lat;
            s_sel    <= {NSLV{1'b0}};
            s_we     <= WE_NONE;
          end else begin
            cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end

        RESP: begin
          // Single-cycle completion pulse, then back to idle.
          state <= IDLE;
          ready <= 1'b0;
          cnt   <= {CNT_W{1'b0}};
        end

        default: begin
          state <= IDLE;
          ready <= 1'b0;
          cnt   <= {CNT_W{1'b0}};
          s_sel <= {NSLV{1'b0}};
          s_we  <= WE_NONE;
        end
      endcase
    end
  end

endmodule
